// File: rtl/smpl_capture_ctrl.sv
// Circular-buffer capture controller: decimates smpl, writes it to RAM,
// sequences pretrigger/trigger/posttrigger and reports the oldest address.
//
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   run                 - start request (IDLE only)
//   triggered           - trigger level
//   decimator           - store one sample every 2^decimator clocks
//   trig_pos            - samples to store after the trigger
//   smpl                - sample word
//   done_ack            - host acknowledge, DONE -> IDLE
//   we, waddr, wdata    - RAM write port
//   armed               - pretrigger history is full enough
//   capture_done        - capture complete
//   trig_addr           - oldest valid sample address
module smpl_capture_ctrl #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              triggered,
  input  logic [3:0]        decimator,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [7:0]        smpl,
  input  logic              done_ack,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [7:0]        wdata,
  output logic              armed,
  output logic              capture_done,
  output logic [ADDR_W-1:0] trig_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t state_q;
  state_t state_d;

  logic [15:0]       dec_cnt;
  logic [15:0]       dec_max;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] wptr_nxt;
  logic [ADDR_W:0]   pre_cnt;
  logic [ADDR_W:0]   thresh;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] post_inc;
  logic              we_post;
  logic              active;
  logic              pre_hit;
  logic              trig_ok;
  logic              post_last;
  logic              strobe;
  logic              start;

  assign dec_max  = (16'd1 << decimator) - 16'd1;
  assign active   = (state_q == S_PRE) || (state_q == S_WAIT) ||
                    (state_q == S_POST);
  // Pointer as it will be after a write completing this edge.
  assign wptr_nxt = we ? wptr + ADDR_W'(1) : wptr;
  assign thresh   = FULL - {1'b0, trig_pos};
  assign pre_hit  = pre_cnt >= thresh;
  assign post_inc = post_cnt + ADDR_W'(1);
  assign trig_ok  = (state_q == S_WAIT) && armed && triggered;
  assign post_last = (state_q == S_POST) && we && we_post &&
                     (post_inc == trig_pos);
  assign start    = (state_q == S_IDLE) && run;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (run) state_d = S_PRE;
      S_PRE:  if (pre_hit) state_d = S_WAIT;
      S_WAIT: if (trig_ok)
                state_d = (trig_pos == '0) ? S_DONE : S_POST;
      S_POST: if (post_last) state_d = S_DONE;
      S_DONE: if (done_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A strobe on the edge entering DONE would leak a write into DONE.
  assign strobe = active && (dec_cnt == dec_max) &&
                  (state_d != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dec_cnt      <= '0;
      wptr         <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      we_post      <= 1'b0;
      we           <= 1'b0;
      waddr        <= '0;
      wdata        <= '0;
      armed        <= 1'b0;
      capture_done <= 1'b0;
      trig_addr    <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        dec_cnt  <= '0;
        wptr     <= '0;
        pre_cnt  <= '0;
        post_cnt <= '0;
        armed    <= 1'b0;
        we       <= 1'b0;
        we_post  <= 1'b0;
      end else begin
        we      <= strobe;
        we_post <= strobe && (state_q == S_POST);
        if (strobe) begin
          waddr <= wptr_nxt;
          wdata <= smpl;
        end
        if (active)
          dec_cnt <= (dec_cnt == dec_max) ? '0 : dec_cnt + 16'd1;
        if (we) begin
          wptr <= wptr + ADDR_W'(1);
          if (pre_cnt != FULL) pre_cnt <= pre_cnt + 1'b1;
          if (we_post) post_cnt <= post_inc;
        end
        if (active && pre_hit) armed <= 1'b1;
        if (state_d == S_DONE && state_q != S_DONE) begin
          capture_done <= 1'b1;
          trig_addr    <= wptr_nxt;
        end
        if (state_q == S_DONE && done_ack) capture_done <= 1'b0;
      end
    end
  end

endmodule
